axil_cfg_fifo: RTL and testbench

Buffered command source for the AXI-Lite write master. It accepts register-write requests (address/data pairs) from configuration logic and stores them in an in-order FIFO. It presents them one at a time on the `s_axi_cfg_w*` request port of the AXI-Lite write master directly downstream. Producers can therefore burst several writes back-to-back without waiting for each AXI-Lite transaction to finish.

---
 rtl/axil_cfg_fifo.sv | 110 +++++++++++
 tb/tb_axil_cfg_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_fifo.sv
// In-order request FIFO feeding the AXI-Lite write master's cfg request port.
// Storage array plus one output register that holds the head entry.
module axil_cfg_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic                  in_valid,
    input  logic [31:0]           in_addr,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  s_axi_cfg_wvalid,
    output logic [31:0]           s_axi_cfg_waddr,
    output logic [31:0]           s_axi_cfg_wdata,
    input  logic                  s_axi_cfg_wready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic [15:0]           issued_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] arr_count;
    logic [PW-1:0] arr_count_next;
    logic [PW-1:0] level_next;

    logic in_fire;
    logic out_fire;
    logic out_free;
    logic arr_empty;
    logic bypass;
    logic refill;
    logic wr_en;

    assign in_fire   = in_valid && in_ready && !flush;
    assign out_fire  = s_axi_cfg_wvalid && s_axi_cfg_wready;
    assign out_free  = !s_axi_cfg_wvalid || out_fire;
    assign arr_empty = (wr_ptr == rd_ptr);
    // Input skips the array only when nothing older is waiting in it.
    assign bypass    = in_fire && arr_empty && out_free;
    assign refill    = out_free && !arr_empty;
    assign wr_en     = in_fire && !bypass;
    assign arr_count = wr_ptr - rd_ptr;

    always_comb begin
        arr_count_next = arr_count + PW'(wr_en) - PW'(refill);
        level_next     = level;
        if (in_fire && !out_fire) begin
            level_next = level + PW'(1);
        end else if (!in_fire && out_fire) begin
            level_next = level - PW'(1);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge s_axi_aclk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            s_axi_cfg_wvalid <= 1'b0;
            s_axi_cfg_waddr  <= '0;
            s_axi_cfg_wdata  <= '0;
            in_ready         <= 1'b0;
            level            <= '0;
            empty            <= 1'b1;
            issued_cnt       <= '0;
        end else if (flush) begin
            // Discard everything, including a handshake landing on this edge.
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            s_axi_cfg_wvalid <= 1'b0;
            in_ready         <= 1'b0;
            level            <= '0;
            empty            <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (refill) begin
                rd_ptr           <= rd_ptr + PW'(1);
                s_axi_cfg_wvalid <= 1'b1;
                {s_axi_cfg_waddr, s_axi_cfg_wdata} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end else if (bypass) begin
                s_axi_cfg_wvalid <= 1'b1;
                s_axi_cfg_waddr  <= in_addr;
                s_axi_cfg_wdata  <= in_data;
            end else if (out_fire) begin
                s_axi_cfg_wvalid <= 1'b0;
            end
            if (out_fire) begin
                issued_cnt <= issued_cnt + 16'd1;
            end
            in_ready <= (arr_count_next <= PW'(DEPTH - 1));
            level    <= level_next;
            empty    <= (level_next == '0);
        end
    end

endmodule

// File: tb/tb_axil_cfg_fifo.sv
// Directed bench for axil_cfg_fifo: a vector table for single-cycle behaviour
// plus scoreboarded sequences for stall, wrap, flush and reset corners.
module tb_axil_cfg_fifo;

    localparam int unsigned DL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        wvalid;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        wready = 1'b0;
    logic [DL:0] level;
    logic        empty;
    logic [15:0] issued;

    int checks = 0;
    int errors = 0;

    logic [63:0] q[$];
    logic [15:0] exp_iss;
    logic [15:0] saved_iss;
    bit          f;
    bit          done;
    int          idx;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic        fl;
        logic        wr;
        logic        e_wv;
        logic [31:0] e_a;
        logic [31:0] e_d;
        logic [4:0]  e_lvl;
        logic        e_rdy;
        logic [15:0] e_iss;
    } vec_t;

    vec_t vecs[11];

    axil_cfg_fifo #(.DEPTH_LOG2(DL)) dut (
        .s_axi_aclk       (clk),
        .s_axi_areset     (rst),
        .in_valid         (in_valid),
        .in_addr          (in_addr),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .flush            (flush),
        .s_axi_cfg_wvalid (wvalid),
        .s_axi_cfg_waddr  (waddr),
        .s_axi_cfg_wdata  (wdata),
        .s_axi_cfg_wready (wready),
        .level            (level),
        .empty            (empty),
        .issued_cnt       (issued)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with scoreboard update from the handshakes seen before the edge.
    task automatic step(output bit inf);
        bit          outf;
        bit          stall;
        logic [63:0] held;
        inf   = in_valid && in_ready && !flush;
        outf  = wvalid && wready && !flush;
        stall = wvalid && !wready && !flush;
        held  = {waddr, wdata};
        if (flush) begin
            q.delete();
        end else begin
            if (outf) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 64'(q.size()), 64'd1);
                end else begin
                    chk("sb_order", {waddr, wdata}, q[0]);
                    void'(q.pop_front());
                end
                exp_iss = exp_iss + 16'd1;
            end
            if (inf) q.push_back({in_addr, in_data});
        end
        @(posedge clk); #1;
        chk("sb_level", 64'(level), 64'(q.size()));
        chk("sb_wvalid", 64'(wvalid), 64'(q.size() != 0));
        chk("sb_empty", 64'(empty), 64'(q.size() == 0));
        chk("sb_issued", 64'(issued), 64'(exp_iss));
        if (wvalid && q.size() != 0) chk("sb_head", {waddr, wdata}, q[0]);
        if (stall) chk("sb_stall_stable", {32'(wvalid), waddr, wdata} , {32'd1, held});
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 1'b0, 32'h0,  32'h0,         5'd0, 1'b1, 16'd0};
        vecs[1]  = '{1'b1, 32'h10, 32'hDEADBEEF,  1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF,  5'd1, 1'b1, 16'd0};
        vecs[2]  = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 1'b0, 32'h0,  32'h0,         5'd0, 1'b1, 16'd1};
        vecs[3]  = '{1'b1, 32'h20, 32'h1,         1'b0, 1'b0, 1'b1, 32'h20, 32'h1,         5'd1, 1'b1, 16'd1};
        vecs[4]  = '{1'b1, 32'h24, 32'h2,         1'b0, 1'b0, 1'b1, 32'h20, 32'h1,         5'd2, 1'b1, 16'd1};
        vecs[5]  = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 1'b1, 32'h24, 32'h2,         5'd1, 1'b1, 16'd2};
        vecs[6]  = '{1'b1, 32'h28, 32'h3,         1'b0, 1'b1, 1'b1, 32'h28, 32'h3,         5'd1, 1'b1, 16'd3};
        vecs[7]  = '{1'b1, 32'h2C, 32'h4,         1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         5'd0, 1'b0, 16'd3};
        vecs[8]  = '{1'b1, 32'h30, 32'h5,         1'b0, 1'b1, 1'b0, 32'h0,  32'h0,         5'd0, 1'b1, 16'd3};
        vecs[9]  = '{1'b1, 32'h34, 32'h6,         1'b0, 1'b0, 1'b1, 32'h34, 32'h6,         5'd1, 1'b1, 16'd3};
        vecs[10] = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 1'b0, 32'h0,  32'h0,         5'd0, 1'b1, 16'd4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_issued", 64'(issued), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            in_valid = vecs[i].v;
            in_addr  = vecs[i].a;
            in_data  = vecs[i].d;
            flush    = vecs[i].fl;
            wready   = vecs[i].wr;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_wvalid", i), 64'(wvalid), 64'(vecs[i].e_wv));
            if (vecs[i].e_wv) chk($sformatf("vec%0d_head", i), {waddr, wdata}, {vecs[i].e_a, vecs[i].e_d});
            chk($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].e_lvl));
            chk($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].e_lvl == 5'd0));
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_issued", i), 64'(issued), 64'(vecs[i].e_iss));
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        exp_iss  = 16'd4;

        // Fill against a stalled sink, then drain and accept the rest
        wready = 1'b0;
        idx = 0;
        for (int c = 0; c < 25; c++) begin
            in_valid = 1'b1;
            in_addr  = 32'h1000 + 32'(idx);
            in_data  = 32'hB000_0000 + 32'(idx);
            step(f);
            if (f) idx++;
        end
        chk("full_accepted", 64'(idx), 64'd17);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_level", 64'(level), 64'd17);
        wready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            in_valid = (idx < 20);
            in_addr  = 32'h1000 + 32'(idx);
            in_data  = 32'hB000_0000 + 32'(idx);
            step(f);
            if (f) idx++;
            if (idx == 20 && q.size() == 0) done = 1'b1;
        end
        chk("full_total", 64'(idx), 64'd20);
        chk("full_drained_issued", 64'(issued), 64'd24);

        // Sink ready one cycle in four, 40 writes across two pointer wraps
        idx = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            wready   = ((c % 4) == 3);
            in_valid = (idx < 40);
            in_addr  = 32'(idx);
            in_data  = 32'hA500_0000 | 32'(idx);
            step(f);
            if (f) idx++;
            if (idx == 40 && q.size() == 0) done = 1'b1;
        end
        chk("pulse_total", 64'(idx), 64'd40);
        chk("pulse_drained", 64'(q.size()), 64'd0);

        // Steady concurrent in/out at level 5
        wready = 1'b0;
        idx = 0;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            in_valid = 1'b1;
            in_addr  = 32'h2000 + 32'(idx);
            in_data  = 32'hC000_0000 + 32'(idx);
            step(f);
            if (f) idx++;
        end
        chk("conc_fill_level", 64'(level), 64'd5);
        wready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_addr  = 32'h2000 + 32'(idx);
            in_data  = 32'hC000_0000 + 32'(idx);
            step(f);
            chk("conc_in_fire", 64'(f), 64'd1);
            if (f) idx++;
            chk("conc_level", 64'(level), 64'd5);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) step(f);
        chk("conc_drained", 64'(level), 64'd0);

        // Flush at level 9 with both handshakes offered
        wready = 1'b0;
        idx = 0;
        for (int c = 0; c < 30 && idx < 9; c++) begin
            in_valid = 1'b1;
            in_addr  = 32'h3000 + 32'(idx);
            in_data  = 32'hD000_0000 + 32'(idx);
            step(f);
            if (f) idx++;
        end
        chk("flush_pre_level", 64'(level), 64'd9);
        saved_iss = issued;
        flush    = 1'b1;
        in_valid = 1'b1;
        wready   = 1'b1;
        step(f);
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_wvalid", 64'(wvalid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        chk("flush_issued", 64'(issued), 64'(saved_iss));
        flush    = 1'b0;
        in_valid = 1'b0;
        step(f);
        chk("flush_in_ready_back", 64'(in_ready), 64'd1);

        // Asynchronous reset with level 6
        wready = 1'b0;
        idx = 0;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            in_valid = 1'b1;
            in_addr  = 32'h4000 + 32'(idx);
            in_data  = 32'hE000_0000 + 32'(idx);
            step(f);
            if (f) idx++;
        end
        in_valid = 1'b0;
        chk("arst_pre_level", 64'(level), 64'd6);
        #2 rst = 1'b1;
        #1;
        chk("arst_wvalid", 64'(wvalid), 64'd0);
        chk("arst_head", {waddr, wdata}, 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_issued", 64'(issued), 64'd0);
        #1 rst = 1'b0;
        q.delete();
        exp_iss = 16'd0;
        step(f);
        chk("arst_in_ready_rise", 64'(in_ready), 64'd1);
        wready   = 1'b1;
        in_valid = 1'b1;
        in_addr  = 32'h50;
        in_data  = 32'h1234_5678;
        step(f);
        in_valid = 1'b0;
        chk("arst_post_head", {waddr, wdata}, {32'h50, 32'h1234_5678});
        step(f);
        chk("arst_post_issued", 64'(issued), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
